line_buffer: RTL and testbench
==============================

# line_buffer

Receive-side line assembler between the UART receiver and whatever consumes text commands. It takes bytes from the UART as they arrive and stores printable characters in an internal byte buffer. Backspace edits the stored line, and every accepted character is echoed to the UART transmitter. On carriage return it terminates the line with 0x00 and holds the line for the consumer, which reads it back through a synchronous read port and releases it with an acknowledge.

## Interface

Parameters:
- Depth, 64, buffer size in bytes including the 0x00 terminator; power of two, ≥ 4.
- Abits, $clog2(Depth), width of addresses and of LEN.

Ports:
- CLK  in  1  single system clock, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- RXC  in  8  received byte from the UART.
- RXV  in  1  one-cycle strobe: RXC is valid this cycle.
- ECHO  out  8  byte to transmit.
- ECHOV  out  1  ECHO is valid; held until accepted.
- ECHORDY  in  1  transmitter ready; a transfer occurs in any cycle with ECHOV & ECHORDY.
- RADDR  in  Abits  consumer read address.
- RDATA  out  8  buffer byte at RADDR, registered.
- LINE  out  1  a complete line is held.
- LEN  out  Abits  character count of the held line, excluding the terminator; valid while LINE=1.
- ACK  in  1  consumer releases the held line.
- OVR  out  1  one-cycle pulse: an RXV byte was dropped.

## Operation

- Internal state:
  - `count` (Abits): next write position.
  - Echo queue of up to 3 bytes.
  - FSM with states FILL, DONE.
- Reset values:
  - State FILL, count=0, echo queue empty.
  - ECHOV=0, ECHO=0x00, LINE=0, LEN=0, OVR=0, RDATA=0x00.
  - Buffer contents are not cleared.
- Drop rule: an RXV byte is dropped, with OVR pulsed, if either:
  - the echo queue is non-empty, or
  - the state is DONE.
- In FILL, when RXV is set and the byte is not dropped:
  - Printable byte (0x20..0x7E) with count < Depth-1: store at buffer[count], count+1, queue echo of the same byte.
  - Printable byte with count = Depth-1: not stored, queue echo 0x07 (BEL). OVR is not pulsed.
  - Backspace (0x08 or 0x7F) with count > 0: count-1, queue echo 0x08, 0x20, 0x08 in that order.
  - Backspace with count = 0: ignored, no echo.
  - CR (0x0D): store 0x00 at buffer[count], LEN=count, queue echo 0x0D, 0x0A, then go to DONE and set LINE=1.
  - Any other byte: ignored, no echo, no OVR.
- DONE:
  - LINE stays 1.
  - ACK → count=0, LINE=0, state FILL.
  - ACK in FILL has no effect.
- The echo queue drains one byte per handshake, in order.
  - ECHO and ECHOV are stable while ECHOV=1 and ECHORDY=0.
  - Queue empty → ECHOV=0.
- Read port: RDATA = buffer[RADDR] registered, available in every state.
  - The consumer only relies on the contents while LINE=1.
- The buffer is a single-write, single-read array inferable as block RAM.

## Timing

- RXV sampled at edge N:
  - buffer write, count, LINE, LEN and OVR update at edge N.
  - ECHOV=1 with the first echo byte from edge N.
- Echo:
  - A transfer at edge M presents the next queued byte from edge M, or ECHOV=0 if none.
  - Minimum echo gap between bytes is zero cycles.
- RDATA reflects RADDR with 1-cycle latency.
  - A same-cycle write to the read address returns the old data.
- LINE rises at the edge that samples CR and falls at the edge that samples ACK.
- RXV arriving in the same cycle as ACK is dropped with OVR, because the state is still DONE.
- RST overrides everything, including mid-echo (queue flushed, ECHOV=0) and DONE (line discarded).

## Test plan

- Type "hi"+CR with ECHORDY=1:
  - echo 0x68, 0x69, 0x0D, 0x0A;
  - LINE=1, LEN=2;
  - reads at 0,1,2 give 0x68, 0x69, 0x00.
- Type "ab", 0x08, "c", CR:
  - echo includes 0x08, 0x20, 0x08;
  - LEN=2; buffer reads "ac" then 0x00.
- With Depth=8, type 9 printable bytes then CR:
  - first 7 stored and echoed, bytes 8-9 echo 0x07;
  - LEN=7, terminator at address 7.
- Hold ECHORDY=0 after the first byte and strobe a second RXV:
  - OVR pulses; the second byte is neither stored nor echoed;
  - ECHO stays stable until ECHORDY=1.
- In DONE, strobe RXV, then assert ACK:
  - OVR pulses and LEN is unchanged;
  - after ACK, LINE=0 and the next "x"+CR gives LEN=1.
- Assert RST during the BS-SP-BS echo:
  - ECHOV=0, LINE=0, LEN=0 the next cycle;
  - the following "z"+CR gives LEN=1.

Source files
------------

// File: rtl/line_buffer.sv
// Receive-side line assembler: collects printable UART bytes into a
// line buffer with backspace editing, echo, and a CR-terminated handoff.
module line_buffer #(
  parameter int Depth = 64,
  parameter int Abits = $clog2(Depth)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       RXC,
  input  logic             RXV,
  output logic [7:0]       ECHO,
  output logic             ECHOV,
  input  logic             ECHORDY,
  input  logic [Abits-1:0] RADDR,
  output logic [7:0]       RDATA,
  output logic             LINE,
  output logic [Abits-1:0] LEN,
  input  logic             ACK,
  output logic             OVR
);

  typedef enum logic {S_FILL, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [Abits-1:0] r_count, w_count;
  logic [Abits-1:0] r_len;
  logic [7:0]       r_mem [Depth];
  logic [7:0]       r_rdata;
  logic [7:0]       r_q0, r_q1, r_q2;
  logic [1:0]       r_qn;
  logic             r_ovr;

  logic             w_drop, w_acc;
  logic             w_print, w_bs, w_cr, w_full;
  logic             w_we, w_len_we;
  logic [7:0]       w_wdata;
  logic [1:0]       w_ldn;
  logic [7:0]       w_ld0, w_ld1, w_ld2;

  assign ECHO  = r_q0;
  assign ECHOV = (r_qn != 2'd0);
  assign RDATA = r_rdata;
  assign LINE  = (r_state == S_DONE);
  assign LEN   = r_len;
  assign OVR   = r_ovr;

  assign w_drop  = RXV & (ECHOV | (r_state == S_DONE));
  assign w_acc   = RXV & ~w_drop;
  assign w_print = (RXC >= 8'h20) && (RXC <= 8'h7E);
  assign w_bs    = (RXC == 8'h08) || (RXC == 8'h7F);
  assign w_cr    = (RXC == 8'h0D);
  assign w_full  = (r_count == Abits'(Depth - 1));

  always_comb begin
    w_next   = r_state;
    w_count  = r_count;
    w_we     = 1'b0;
    w_wdata  = RXC;
    w_len_we = 1'b0;
    w_ldn    = 2'd0;
    w_ld0    = 8'h00;
    w_ld1    = 8'h00;
    w_ld2    = 8'h00;
    if (w_acc) begin
      unique case (1'b1)
        w_print: begin
          w_ldn = 2'd1;
          if (w_full) begin
            w_ld0 = 8'h07;
          end else begin
            w_we    = 1'b1;
            w_count = r_count + 1'b1;
            w_ld0   = RXC;
          end
        end
        w_bs: begin
          if (r_count != '0) begin
            w_count = r_count - 1'b1;
            w_ldn   = 2'd3;
            w_ld0   = 8'h08;
            w_ld1   = 8'h20;
            w_ld2   = 8'h08;
          end
        end
        w_cr: begin
          w_we     = 1'b1;
          w_wdata  = 8'h00;
          w_len_we = 1'b1;
          w_ldn    = 2'd2;
          w_ld0    = 8'h0D;
          w_ld1    = 8'h0A;
          w_next   = S_DONE;
        end
        default: ;
      endcase
    end
    if ((r_state == S_DONE) && ACK) begin
      w_next  = S_FILL;
      w_count = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_FILL;
      r_count <= '0;
      r_len   <= '0;
      r_ovr   <= 1'b0;
      r_qn    <= 2'd0;
      r_q0    <= 8'h00;
      r_q1    <= 8'h00;
      r_q2    <= 8'h00;
    end else begin
      r_state <= w_next;
      r_count <= w_count;
      r_ovr   <= w_drop;
      if (w_len_we) r_len <= r_count;
      // loads only happen with an empty queue, so never collide with a shift
      if (w_ldn != 2'd0) begin
        r_qn <= w_ldn;
        r_q0 <= w_ld0;
        r_q1 <= w_ld1;
        r_q2 <= w_ld2;
      end else if (ECHOV && ECHORDY) begin
        r_qn <= r_qn - 2'd1;
        r_q0 <= r_q1;
        r_q1 <= r_q2;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we && !RST) r_mem[r_count] <= w_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) r_rdata <= 8'h00;
    else     r_rdata <= r_mem[RADDR];
  end

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer (Depth=8): typing, editing, overflow,
// echo back-pressure, DONE drops and reset recovery.
module tb_line_buffer;

  logic       CLK = 1'b0;
  logic       RST, RXV, ECHORDY, ACK;
  logic [7:0] RXC, ECHO, RDATA;
  logic       ECHOV, LINE, OVR;
  logic [2:0] RADDR, LEN;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] echoq [$];

  line_buffer #(.Depth(8)) dut (
    .CLK(CLK), .RST(RST), .RXC(RXC), .RXV(RXV),
    .ECHO(ECHO), .ECHOV(ECHOV), .ECHORDY(ECHORDY),
    .RADDR(RADDR), .RDATA(RDATA), .LINE(LINE), .LEN(LEN),
    .ACK(ACK), .OVR(OVR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (ECHOV && ECHORDY && !RST) echoq.push_back(ECHO);

  function automatic logic [127:0] packq();
    logic [127:0] v = '0;
    foreach (echoq[i]) v = {v[119:0], echoq[i]};
    return v;
  endfunction

  task automatic send(input logic [7:0] c);
    @(posedge CLK); #1;
    RXC = c; RXV = 1'b1;
    @(posedge CLK); #1;
    RXV = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (!ECHOV) done = 1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL echo_timeout ECHOV stuck at %0b want 0", ECHOV);
    end
  endtask

  task automatic type_b(input logic [7:0] c);
    send(c);
    wait_idle();
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string nm);
    @(posedge CLK); #1;
    RADDR = a;
    @(posedge CLK);
    @(negedge CLK);
    n_total++;
    if (RDATA !== exp) $display("FAIL %s got %h want %h", nm, RDATA, exp);
    else n_pass++;
  endtask

  task automatic ack();
    @(posedge CLK); #1; ACK = 1'b1;
    @(posedge CLK); #1; ACK = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_total++;
    if ({ECHOV, LINE, OVR} !== 3'b000) $display("FAIL rst_flags got %b want 000", {ECHOV, LINE, OVR});
    else n_pass++;
    n_total++;
    if (ECHO !== 8'h00) $display("FAIL rst_echo got %h want 00", ECHO);
    else n_pass++;
    n_total++;
    if (LEN !== 3'd0) $display("FAIL rst_len got %0d want 0", LEN);
    else n_pass++;
    n_total++;
    if (RDATA !== 8'h00) $display("FAIL rst_rdata got %h want 00", RDATA);
    else n_pass++;
    @(posedge CLK); #1; RST = 1'b0;
  endtask

  task automatic test_hi();
    echoq.delete();
    type_b(8'h68); type_b(8'h69); type_b(8'h0D);
    n_total++;
    if (packq() !== 128'h68690D0A) $display("FAIL hi_echo got %h want 68690d0a", packq());
    else n_pass++;
    n_total++;
    if (LINE !== 1'b1 || LEN !== 3'd2) $display("FAIL hi_line got %b/%0d want 1/2", LINE, LEN);
    else n_pass++;
    rd(0, 8'h68, "hi_rd0"); rd(1, 8'h69, "hi_rd1"); rd(2, 8'h00, "hi_rd2");
    ack();
    @(negedge CLK);
    n_total++;
    if (LINE !== 1'b0) $display("FAIL hi_ack got %b want 0", LINE);
    else n_pass++;
  endtask

  task automatic test_backspace();
    echoq.delete();
    type_b(8'h08);
    send(8'h01);
    @(negedge CLK);
    n_total++;
    if (OVR !== 1'b0) $display("FAIL bs_ctrl_ovr got %b want 0", OVR);
    else n_pass++;
    wait_idle();
    type_b(8'h61); type_b(8'h62); type_b(8'h08); type_b(8'h63); type_b(8'h0D);
    n_total++;
    if (packq() !== 128'h616208200863_0D0A) $display("FAIL bs_echo got %h want 6162082008630d0a", packq());
    else n_pass++;
    n_total++;
    if (LEN !== 3'd2) $display("FAIL bs_len got %0d want 2", LEN);
    else n_pass++;
    rd(0, 8'h61, "bs_rd0"); rd(1, 8'h63, "bs_rd1"); rd(2, 8'h00, "bs_rd2");
    ack();
  endtask

  task automatic test_overflow();
    echoq.delete();
    for (int i = 0; i < 9; i++) type_b(8'h41 + 8'(i));
    type_b(8'h0D);
    n_total++;
    if (packq() !== 128'h41424344454647_0707_0D0A) $display("FAIL ovf_echo got %h want 4142434445464707070d0a", packq());
    else n_pass++;
    n_total++;
    if (LEN !== 3'd7) $display("FAIL ovf_len got %0d want 7", LEN);
    else n_pass++;
    rd(6, 8'h47, "ovf_rd6"); rd(7, 8'h00, "ovf_rd7");
    ack();
  endtask

  task automatic test_stall();
    echoq.delete();
    ECHORDY = 1'b0;
    send(8'h70);
    send(8'h71);
    @(negedge CLK);
    n_total++;
    if (OVR !== 1'b1) $display("FAIL stall_ovr got %b want 1", OVR);
    else n_pass++;
    repeat (3) @(negedge CLK);
    n_total++;
    if (ECHOV !== 1'b1 || ECHO !== 8'h70 || OVR !== 1'b0)
      $display("FAIL stall_hold got %b/%h/%b want 1/70/0", ECHOV, ECHO, OVR);
    else n_pass++;
    @(posedge CLK); #1; ECHORDY = 1'b1;
    wait_idle();
    n_total++;
    if (packq() !== 128'h70) $display("FAIL stall_echo got %h want 70", packq());
    else n_pass++;
    type_b(8'h0D);
    n_total++;
    if (LEN !== 3'd1) $display("FAIL stall_len got %0d want 1", LEN);
    else n_pass++;
    rd(1, 8'h00, "stall_rd1");
    ack();
  endtask

  task automatic test_done_drop();
    type_b(8'h78); type_b(8'h0D);
    send(8'h79);
    @(negedge CLK);
    n_total++;
    if (OVR !== 1'b1 || LEN !== 3'd1) $display("FAIL done_ovr got %b/%0d want 1/1", OVR, LEN);
    else n_pass++;
    @(posedge CLK); #1;
    RXC = 8'h79; RXV = 1'b1; ACK = 1'b1;
    @(posedge CLK); #1;
    RXV = 1'b0; ACK = 1'b0;
    @(negedge CLK);
    n_total++;
    if (OVR !== 1'b1 || LINE !== 1'b0) $display("FAIL ack_rxv got %b/%b want 1/0", OVR, LINE);
    else n_pass++;
    type_b(8'h78); type_b(8'h0D);
    n_total++;
    if (LINE !== 1'b1 || LEN !== 3'd1) $display("FAIL done_relen got %b/%0d want 1/1", LINE, LEN);
    else n_pass++;
    rd(0, 8'h78, "done_rd0");
    ack();
  endtask

  task automatic test_reset_mid();
    type_b(8'h61);
    send(8'h08);
    RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    n_total++;
    if ({ECHOV, LINE, LEN} !== 5'b0) $display("FAIL rstmid got %b/%b/%0d want 0/0/0", ECHOV, LINE, LEN);
    else n_pass++;
    type_b(8'h77); type_b(8'h0D);
    @(posedge CLK); #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    n_total++;
    if ({LINE, LEN} !== 4'b0) $display("FAIL rstdone got %b/%0d want 0/0", LINE, LEN);
    else n_pass++;
    echoq.delete();
    type_b(8'h7A); type_b(8'h0D);
    n_total++;
    if (LEN !== 3'd1 || packq() !== 128'h7A0D0A) $display("FAIL rst_z got %0d/%h want 1/7a0d0a", LEN, packq());
    else n_pass++;
    rd(0, 8'h7A, "rst_rd0");
  endtask

  initial begin
    RST = 1'b1; RXV = 1'b0; RXC = 8'h00;
    ECHORDY = 1'b1; ACK = 1'b0; RADDR = 3'd0;
    test_reset();
    test_hi();
    test_backspace();
    test_overflow();
    test_stall();
    test_done_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
